instr_fetch_seq: RTL and testbench

INSTR_FETCH_SEQ -- requirements
Module: instr_fetch_seq

---
 rtl/instr_fetch_seq_if.sv | 21 ++
 rtl/instr_fetch_seq.sv | 131 +++++++++++++
 tb/tb_instr_fetch_seq.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_seq_if.sv
// Instruction-memory request/response bus between the fetch sequencer and memory.
interface instr_fetch_seq_if;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_valid;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_valid
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_valid
   );
endinterface

// File: rtl/instr_fetch_seq.sv
// Fetch/execute sequencer for a single-cycle datapath: fetches one instruction at a
// time, presents it for one cycle, then advances the PC (sequential or branch).
module instr_fetch_seq #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   instr_fetch_seq_if.master  imem,
   output logic [31:0]        instr,
   output logic               instr_valid,
   input  logic               branch_taken,
   input  logic [63:0]        branch_target,
   output logic [63:0]        pc,
   output logic               halted,
   output logic               err,
   output logic [31:0]        retired
);

   typedef enum logic [2:0] {IDLE, FETCH, EXEC, HALT, ERROR} state_t;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   // Last count value before the TIMEOUT-th response-less FETCH cycle.
   localparam logic [7:0]  TCNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        instr_valid_q, instr_valid_d;
   logic        req_q, req_d;
   logic        halted_q, halted_d;
   logic        err_q, err_d;
   logic [31:0] retired_q, retired_d;
   logic [7:0]  tcnt_q, tcnt_d;

   // Next-state and next-output decode; every register holds unless a transition says otherwise.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_valid_d = 1'b0;
      req_d         = req_q;
      halted_d      = halted_q;
      err_d         = err_q;
      retired_d     = retired_q;
      tcnt_d        = tcnt_q;

      unique case (state_q)
         IDLE, HALT, ERROR: begin
            if (start) begin
               state_d   = FETCH;
               pc_d      = RESET_PC;
               retired_d = 32'h0;
               tcnt_d    = 8'h0;
               req_d     = 1'b1;
               halted_d  = 1'b0;
               err_d     = 1'b0;
            end
         end
         FETCH: begin
            if (imem.imem_valid) begin
               // A response in the last allowed cycle still wins over the timeout.
               state_d       = EXEC;
               instr_d       = imem.imem_rdata;
               instr_valid_d = 1'b1;
               req_d         = 1'b0;
            end else if (tcnt_q == TCNT_LAST) begin
               state_d = ERROR;
               req_d   = 1'b0;
               err_d   = 1'b1;
            end else begin
               tcnt_d = tcnt_q + 8'h1;
            end
         end
         EXEC: begin
            retired_d = retired_q + 32'h1;
            pc_d      = branch_taken ? {branch_target[63:1], 1'b0} : pc_q + 64'd4;
            if (instr_q == ECALL || instr_q == EBREAK) begin
               state_d  = HALT;
               halted_d = 1'b1;
            end else begin
               state_d = FETCH;
               req_d   = 1'b1;
               tcnt_d  = 8'h0;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset abandons any outstanding fetch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= NOP;
         instr_valid_q <= 1'b0;
         req_q         <= 1'b0;
         halted_q      <= 1'b0;
         err_q         <= 1'b0;
         retired_q     <= 32'h0;
         tcnt_q        <= 8'h0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         req_q         <= req_d;
         halted_q      <= halted_d;
         err_q         <= err_d;
         retired_q     <= retired_d;
         tcnt_q        <= tcnt_d;
      end
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc_q;
   assign pc             = pc_q;
   assign instr          = instr_q;
   assign instr_valid    = instr_valid_q;
   assign halted         = halted_q;
   assign err            = err_q;
   assign retired        = retired_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: directed scenarios plus a randomized
// program run, checked against an instruction-level model (pc/retired per retire).
module tb_instr_fetch_seq;

   localparam logic [63:0] RPC = 64'h0;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] instr;
   logic        instr_valid;
   logic        branch_taken;
   logic [63:0] branch_target;
   logic [63:0] pc;
   logic        halted;
   logic        err;
   logic [31:0] retired;

   instr_fetch_seq_if bus ();

   instr_fetch_seq #(.RESET_PC(RPC), .TIMEOUT(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .imem          (bus.master),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .pc            (pc),
      .halted        (halted),
      .err           (err),
      .retired       (retired)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [63:0] m_pc;
   logic [31:0] m_ret;

   // Start pulse from IDLE/HALT/ERROR; afterwards the bench sits in the first FETCH cycle.
   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      m_pc  = RPC;
      m_ret = 32'h0;
      if (bus.imem_req !== 1'b1 || pc !== RPC || retired !== 32'h0) begin
         n_err++;
         $display("FAIL start: req=%b pc=%h ret=%0d want req=1 pc=%h ret=0",
                  bus.imem_req, pc, retired, RPC);
      end
      n_cmp++;
      if (halted !== 1'b0 || err !== 1'b0) begin
         n_err++;
         $display("FAIL start_flags: halted=%b err=%b want 0 0", halted, err);
      end
      n_cmp++;
   endtask

   task automatic restart();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      do_start();
   endtask

   // One instruction: lat response-less FETCH cycles, response, EXEC, then retire checks.
   task automatic run_instr(input logic [31:0] w, input int lat, input logic take,
                            input logic [63:0] tgt, input bit noisy);
      bit sys;
      sys = (w == 32'h0000_0073) || (w == 32'h0010_0073);
      for (int i = 0; i <= lat; i++) begin
         if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_req: req=%b addr=%h iv=%b want req=1 addr=%h iv=0",
                     bus.imem_req, bus.imem_addr, instr_valid, m_pc);
         end
         n_cmp++;
         start = noisy ? 1'($urandom_range(1, 0)) : 1'b0;
         bus.imem_valid = (i == lat);
         bus.imem_rdata = (i == lat) ? w : $urandom;
         @(negedge clk);
      end
      if (instr_valid !== 1'b1 || instr !== w || bus.imem_req !== 1'b0 || pc !== m_pc) begin
         n_err++;
         $display("FAIL exec: iv=%b instr=%h req=%b pc=%h want iv=1 instr=%h req=0 pc=%h",
                  instr_valid, instr, bus.imem_req, pc, w, m_pc);
      end
      n_cmp++;
      branch_taken   = take;
      branch_target  = tgt;
      start          = noisy ? 1'($urandom_range(1, 0)) : 1'b0;
      bus.imem_valid = noisy ? 1'($urandom_range(1, 0)) : 1'b0;
      bus.imem_rdata = $urandom;
      @(negedge clk);
      start          = 1'b0;
      bus.imem_valid = 1'b0;
      branch_taken   = 1'b0;
      m_ret = m_ret + 32'h1;
      m_pc  = take ? (tgt & ~64'h1) : m_pc + 64'd4;
      if (pc !== m_pc || retired !== m_ret) begin
         n_err++;
         $display("FAIL retire: pc=%h ret=%0d want pc=%h ret=%0d", pc, retired, m_pc, m_ret);
      end
      n_cmp++;
      if (halted !== sys || bus.imem_req !== !sys || instr_valid !== 1'b0) begin
         n_err++;
         $display("FAIL next_state: halted=%b req=%b iv=%b want halted=%b req=%b iv=0",
                  halted, bus.imem_req, instr_valid, sys, !sys);
      end
      n_cmp++;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b1;
      repeat (2) @(negedge clk);
      if (bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0 || err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: req=%b iv=%b halted=%b err=%b want all 0",
                  bus.imem_req, instr_valid, halted, err);
      end
      n_cmp++;
      if (pc !== RPC || instr !== 32'h13 || retired !== 32'h0) begin
         n_err++;
         $display("FAIL reset_data: pc=%h instr=%h ret=%0d want %h 00000013 0",
                  pc, instr, retired, RPC);
      end
      n_cmp++;
      rst = 1'b0;
      #1;
      if (bus.imem_req !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: req=%b want 0 before first edge", bus.imem_req);
      end
      n_cmp++;
      @(negedge clk);
      start = 1'b0;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== RPC) begin
         n_err++;
         $display("FAIL reset_start: req=%b addr=%h want 1 %h", bus.imem_req, bus.imem_addr, RPC);
      end
      n_cmp++;
   endtask

   task automatic test_first_fetch();
      restart();
      run_instr(32'h0050_0093, 1, 1'b0, 64'h0, 1'b0);
      if (pc !== 64'h4 || retired !== 32'd1) begin
         n_err++;
         $display("FAIL first_fetch: pc=%h ret=%0d want 4 1", pc, retired);
      end
      n_cmp++;
   endtask

   task automatic test_branch();
      restart();
      run_instr(32'h0050_0093, 0, 1'b0, 64'h0, 1'b0);
      run_instr(32'h0020_8463, 2, 1'b1, 64'h40, 1'b0);
      if (bus.imem_addr !== 64'h40 || retired !== 32'd2) begin
         n_err++;
         $display("FAIL branch: addr=%h ret=%0d want 40 2", bus.imem_addr, retired);
      end
      n_cmp++;
   endtask

   task automatic test_ecall_halt();
      restart();
      run_instr(32'h0050_0093, 0, 1'b0, 64'h0, 1'b0);
      run_instr(32'h0010_0113, 1, 1'b0, 64'h0, 1'b0);
      run_instr(32'h0000_0073, 0, 1'b0, 64'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         bus.imem_valid = 1'b1;
         bus.imem_rdata = $urandom;
         @(negedge clk);
         if (halted !== 1'b1 || pc !== 64'hC || bus.imem_req !== 1'b0 || instr_valid !== 1'b0 ||
             instr !== 32'h73 || retired !== 32'd3) begin
            n_err++;
            $display("FAIL halt_hold: halted=%b pc=%h req=%b iv=%b instr=%h ret=%0d",
                     halted, pc, bus.imem_req, instr_valid, instr, retired);
         end
         n_cmp++;
      end
      bus.imem_valid = 1'b0;
      do_start();
   endtask

   task automatic test_timeout();
      restart();
      for (int i = 1; i <= 16; i++) begin
         if (err !== 1'b0 || bus.imem_req !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_wait: cycle=%0d err=%b req=%b want 0 1", i, err, bus.imem_req);
         end
         n_cmp++;
         @(negedge clk);
      end
      if (err !== 1'b1 || bus.imem_req !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_err: err=%b req=%b want 1 0", err, bus.imem_req);
      end
      n_cmp++;
      bus.imem_valid = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
      repeat (2) @(negedge clk);
      bus.imem_valid = 1'b0;
      if (err !== 1'b1 || instr !== 32'h13 || instr_valid !== 1'b0 || pc !== RPC) begin
         n_err++;
         $display("FAIL error_hold: err=%b instr=%h iv=%b pc=%h want 1 00000013 0 %h",
                  err, instr, instr_valid, pc, RPC);
      end
      n_cmp++;
      do_start();
      // Response in the 16th FETCH cycle wins over the timeout.
      run_instr(32'h0030_0193, 15, 1'b0, 64'h0, 1'b0);
      if (err !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_edge: err=%b want 0", err);
      end
      n_cmp++;
   endtask

   task automatic test_reset_mid_fetch();
      restart();
      run_instr(32'h0000_006F, 0, 1'b1, 64'h20, 1'b0);
      @(negedge clk);
      if (bus.imem_addr !== 64'h20 || bus.imem_req !== 1'b1) begin
         n_err++;
         $display("FAIL mid_fetch_pre: addr=%h req=%b want 20 1", bus.imem_addr, bus.imem_req);
      end
      n_cmp++;
      rst = 1'b1;
      #1;
      if (bus.imem_req !== 1'b0 || pc !== RPC || retired !== 32'h0 || instr !== 32'h13) begin
         n_err++;
         $display("FAIL mid_fetch_rst: req=%b pc=%h ret=%0d instr=%h", bus.imem_req, pc, retired,
                  instr);
      end
      n_cmp++;
      @(negedge clk);
      rst = 1'b0;
      bus.imem_valid = 1'b1;
      bus.imem_rdata = 32'h0050_0093;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h13 || pc !== RPC) begin
            n_err++;
            $display("FAIL late_valid: req=%b iv=%b instr=%h pc=%h want idle",
                     bus.imem_req, instr_valid, instr, pc);
         end
         n_cmp++;
      end
      bus.imem_valid = 1'b0;
   endtask

   task automatic test_wrap();
      restart();
      run_instr(32'h0000_006F, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
      run_instr(32'h0050_0093, 0, 1'b0, 64'h0, 1'b0);
      if (pc !== 64'h0) begin
         n_err++;
         $display("FAIL pc_wrap: pc=%h want 0", pc);
      end
      n_cmp++;
      run_instr(32'h0000_006F, 1, 1'b1, 64'h41, 1'b0);
      if (pc !== 64'h40) begin
         n_err++;
         $display("FAIL target_bit0: pc=%h want 40", pc);
      end
      n_cmp++;
   endtask

   task automatic test_random_program();
      logic [31:0] w;
      restart();
      for (int k = 0; k < 60; k++) begin
         w = $urandom;
         if (w == 32'h0000_0073 || w == 32'h0010_0073) w = 32'h13;
         run_instr(w, $urandom_range(15, 0), 1'($urandom_range(1, 0)),
                   {$urandom, $urandom}, 1'b1);
      end
      run_instr(32'h0010_0073, $urandom_range(15, 0), 1'b0, 64'h0, 1'b1);
      if (retired !== 32'd61) begin
         n_err++;
         $display("FAIL random_retired: ret=%0d want 61", retired);
      end
      n_cmp++;
   endtask

   initial begin
      rst            = 1'b1;
      start          = 1'b0;
      branch_taken   = 1'b0;
      branch_target  = 64'h0;
      bus.imem_valid = 1'b0;
      bus.imem_rdata = 32'h0;
      @(negedge clk);
      test_reset();
      test_first_fetch();
      test_branch();
      test_ecall_halt();
      test_timeout();
      test_reset_mid_fetch();
      test_wrap();
      test_random_program();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
